phase_sequence_monitor: RTL
===========================

# phase_sequence_monitor

Receiver-side checker for the four-phase one-hot bus (Phase0..Phase3) driven by the team's phase ring counter. Samples the phases on the shared phase clock, decodes them to a 2-bit index, and acquires lock after a run of legal advances. Once locked, counts completed revolutions and traps illegal codes, out-of-order steps and stalls into a sticky fault that software must acknowledge.

## Interface
- HOLD_MAX, 2, max consecutive samples of one phase before a stall is declared (≥1)
- LOCK_N, 2, legal advances required in ACQUIRE before LOCKED (≥1)
- CNT_W, 8, width of the revolution counter
- Phase_Count  in  1  clock; all logic on rising edge
- Clear  in  1  reset; synchronous, active-high
- Phase0, Phase1, Phase2, Phase3  in  1 each  phase bus; legal code is exactly one bit high
- Enable  in  1  monitor enable
- Err_Ack  in  1  clears FAULT
- Phase_Index  out  2  index of last sampled legal phase
- Valid  out  1  last sample was a legal one-hot code
- Locked  out  1  FSM in LOCKED
- Rev_Count  out  CNT_W  completed 3→0 revolutions while locked; wraps
- Rev_Tick  out  1  one-cycle pulse per revolution
- Err  out  1  FSM in FAULT
- Err_Code  out  2  00 none, 01 illegal code, 10 out-of-order, 11 stall

## Operation
- Sample stage: edge k registers {Phase3..Phase0} into S and updates Valid/Phase_Index from it. Valid=1 iff popcount(S)==1. Phase_Index holds its old value when Valid=0.
- Classification of S against previous index P: SAME (index==P), NEXT (index==P+1 mod 4), BAD_ORDER (other legal index), ILLEGAL (Valid=0: 0000 or multi-hot).
- Hold counter H: set to 1 on every entry or NEXT, incremented on SAME, saturating at HOLD_MAX+1.
- States:
  - HUNT: on a legal sample, load P, set H=1 and adv=0, go to ACQUIRE. Illegal samples are ignored.
  - ACQUIRE: SAME increments H; if H would exceed HOLD_MAX, go to HUNT. NEXT updates P, sets H=1 and increments adv; when adv reaches LOCK_N, go to LOCKED. BAD_ORDER or ILLEGAL go to HUNT. No errors are raised while acquiring.
  - LOCKED: SAME increments H; exceeding HOLD_MAX goes to FAULT with code 11. NEXT updates P and sets H=1; a 3→0 step also increments Rev_Count (mod 2^CNT_W) and pulses Rev_Tick. ILLEGAL goes to FAULT with code 01. BAD_ORDER goes to FAULT with code 10.
  - FAULT: Err=1 and Err_Code is held. Ignores phases. Err_Ack=1 clears Err_Code to 00 and goes to HUNT.
- Enable=0: from HUNT, ACQUIRE or LOCKED, go to HUNT. FAULT persists. Rev_Count is retained and Rev_Tick=0. The sample stage keeps running.
- Priority per edge: Clear > Err_Ack (in FAULT) > Enable=0 > phase classification.
- Only the first fault is recorded. Later events never overwrite Err_Code.
- Rev_Count is cleared only by Clear. It survives FAULT and HUNT.

## Timing
- Clear=1 at an edge: state goes to HUNT. Phase_Index, Valid, Locked, Rev_Count, Rev_Tick, Err and Err_Code are all 0, and S, P, H and adv are all 0. Clear is honoured in every state.
- Latency: a phase value present at edge k appears on Valid/Phase_Index after edge k. Locked, Err, Err_Code, Rev_Count and Rev_Tick react to that sample after edge k+1.
- Rev_Tick is high for exactly one cycle, in the same cycle that Rev_Count shows its incremented value.
- Locked falls in the same cycle that Err rises.
- Err_Ack in FAULT: Err=0 and Err_Code=00 after the next edge. Re-lock needs a fresh 1+LOCK_N legal samples.
- Err_Ack outside FAULT has no effect.
- Wrap: Rev_Count = 2^CNT_W−1 plus one revolution gives 0, and Rev_Tick still pulses.

## Test plan
- Clear, Enable=1, HOLD_MAX=2, LOCK_N=2. Phases 0,0,1,1,2,2,3,3 (one value per edge) -> Locked=1 one edge after the first Phase2 sample. Err=0 and Valid=1 throughout.
- Locked, run three full revolutions at 2 samples per phase -> Rev_Count=3. Three single-cycle Rev_Tick pulses, each one edge after the first Phase0 sample following Phase3.
- Locked, drive 0101 for one sample -> Err=1, Err_Code=01, Locked=0, Rev_Count unchanged. Then Err_Ack=1 for one cycle -> Err=0, Err_Code=00, state HUNT. Legal sequence re-locks.
- Locked at Phase1, jump to Phase3 -> Err_Code=10. A subsequent 0000 sample leaves Err_Code=10.
- Locked, hold Phase2 for 3 samples -> Err_Code=11 one edge after the third sample. In ACQUIRE the same stall gives HUNT with Err=0.
- CNT_W=2: 4 locked revolutions -> Rev_Count 1,2,3,0. Then Clear mid-LOCKED with Rev_Count=1 -> all outputs 0 after that edge. Enable=0 while locked -> Locked=0 and Rev_Count retained.

Source files
------------

// File: rtl/phase_sequence_monitor.sv
`default_nettype none
// ============================================================================
// Module   : phase_sequence_monitor
// Purpose  : Receiver-side checker for a four-phase one-hot bus. Samples the
//            phases, decodes a 2-bit index, acquires lock after a run of legal
//            advances, counts revolutions while locked and traps illegal
//            codes, out-of-order steps and stalls into a sticky fault.
// Ports    : Phase_Count        - clock, rising edge
//            Clear              - synchronous active-high reset
//            Phase0..Phase3     - phase bus, legal code is exactly one-hot
//            Enable             - monitor enable
//            Err_Ack            - acknowledges and clears a fault
//            Phase_Index [1:0]  - index of last legal sample
//            Valid              - last sample was one-hot
//            Locked             - monitor is in LOCKED
//            Rev_Count [CNT_W]  - completed 3->0 revolutions while locked
//            Rev_Tick           - one-cycle pulse per revolution
//            Err                - monitor is in FAULT
//            Err_Code [1:0]     - 00 none, 01 illegal, 10 out-of-order, 11 stall
// Revision : 1.0 - initial release
// ============================================================================
module phase_sequence_monitor #(
  parameter int HOLD_MAX = 2,
  parameter int LOCK_N   = 2,
  parameter int CNT_W    = 8
) (
  input  logic             Phase_Count,
  input  logic             Clear,
  input  logic             Phase0,
  input  logic             Phase1,
  input  logic             Phase2,
  input  logic             Phase3,
  input  logic             Enable,
  input  logic             Err_Ack,
  output logic [1:0]       Phase_Index,
  output logic             Valid,
  output logic             Locked,
  output logic [CNT_W-1:0] Rev_Count,
  output logic             Rev_Tick,
  output logic             Err,
  output logic [1:0]       Err_Code
);

  // Hold counter must reach HOLD_MAX+1; advance counter must reach LOCK_N.
  localparam int c_HOLD_W = $clog2(HOLD_MAX + 2);
  localparam int c_ADV_W  = $clog2(LOCK_N + 1);

  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(HOLD_MAX);
  localparam logic [c_HOLD_W-1:0] c_HOLD_SAT = c_HOLD_W'(HOLD_MAX + 1);
  localparam logic [c_ADV_W-1:0]  c_ADV_ONE  = c_ADV_W'(1);
  localparam logic [c_ADV_W-1:0]  c_ADV_LAST = c_ADV_W'(LOCK_N - 1);
  localparam logic [CNT_W-1:0]    c_REV_ONE  = CNT_W'(1);

  localparam logic [1:0] c_CODE_NONE    = 2'b00;
  localparam logic [1:0] c_CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] c_CODE_ORDER   = 2'b10;
  localparam logic [1:0] c_CODE_STALL   = 2'b11;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Sample stage. The registered pair (r_valid, r_index) is the sampled
  // word S: r_index keeps its previous value across illegal samples.
  // --------------------------------------------------------------------------
  logic [3:0] w_bus;
  logic       w_bus_legal;
  logic [1:0] w_bus_idx;

  assign w_bus       = {Phase3, Phase2, Phase1, Phase0};
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_bus_legal = (w_bus != 4'd0) && ((w_bus & (w_bus - 4'd1)) == 4'd0);

  always_comb begin
    w_bus_idx = 2'd0;
    case (w_bus)
      4'b0010: w_bus_idx = 2'd1;
      4'b0100: w_bus_idx = 2'd2;
      4'b1000: w_bus_idx = 2'd3;
      default: w_bus_idx = 2'd0;
    endcase
  end

  logic       r_valid;
  logic [1:0] r_index;

  always_ff @(posedge Phase_Count) begin
    if (Clear) begin
      r_valid <= 1'b0;
      r_index <= 2'd0;
    end else begin
      r_valid <= w_bus_legal;
      if (w_bus_legal) begin
        r_index <= w_bus_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequence FSM, classifying the registered sample against the last index.
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [1:0]          r_prev;
  logic [c_HOLD_W-1:0] r_hold;
  logic [c_ADV_W-1:0]  r_adv;
  logic                r_locked;
  logic [CNT_W-1:0]    r_rev_count;
  logic                r_rev_tick;
  logic                r_err;
  logic [1:0]          r_err_code;

  logic [1:0]          w_prev_next;
  logic                w_same;
  logic                w_next;
  logic                w_hold_over;
  logic [c_HOLD_W-1:0] w_hold_inc;

  assign w_prev_next = r_prev + 2'd1;
  assign w_same      = r_valid && (r_index == r_prev);
  assign w_next      = r_valid && (r_index == w_prev_next);
  // One more SAME sample would push the hold count past HOLD_MAX.
  assign w_hold_over = (r_hold >= c_HOLD_MAX);
  assign w_hold_inc  = (r_hold == c_HOLD_SAT) ? r_hold : (r_hold + c_HOLD_ONE);

  always_ff @(posedge Phase_Count) begin
    if (Clear) begin
      r_state     <= ST_HUNT;
      r_prev      <= 2'd0;
      r_hold      <= '0;
      r_adv       <= '0;
      r_locked    <= 1'b0;
      r_rev_count <= '0;
      r_rev_tick  <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= c_CODE_NONE;
    end else begin
      r_rev_tick <= 1'b0;
      if (r_state == ST_FAULT) begin
        // The fault is sticky: only an acknowledge leaves it, whatever Enable.
        if (Err_Ack) begin
          r_state    <= ST_HUNT;
          r_err      <= 1'b0;
          r_err_code <= c_CODE_NONE;
        end
      end else if (!Enable) begin
        r_state  <= ST_HUNT;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          ST_HUNT: begin
            if (r_valid) begin
              r_prev  <= r_index;
              r_hold  <= c_HOLD_ONE;
              r_adv   <= '0;
              r_state <= ST_ACQUIRE;
            end
          end
          ST_ACQUIRE: begin
            if (w_same) begin
              r_hold <= w_hold_inc;
              if (w_hold_over) begin
                r_state <= ST_HUNT;
              end
            end else if (w_next) begin
              r_prev <= r_index;
              r_hold <= c_HOLD_ONE;
              r_adv  <= r_adv + c_ADV_ONE;
              if (r_adv == c_ADV_LAST) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_state <= ST_HUNT;
            end
          end
          ST_LOCKED: begin
            if (w_same) begin
              r_hold <= w_hold_inc;
              if (w_hold_over) begin
                r_state    <= ST_FAULT;
                r_locked   <= 1'b0;
                r_err      <= 1'b1;
                r_err_code <= c_CODE_STALL;
              end
            end else if (w_next) begin
              r_prev <= r_index;
              r_hold <= c_HOLD_ONE;
              // A NEXT step landing on phase 0 is the 3->0 wrap.
              if (r_index == 2'd0) begin
                r_rev_count <= r_rev_count + c_REV_ONE;
                r_rev_tick  <= 1'b1;
              end
            end else begin
              r_state    <= ST_FAULT;
              r_locked   <= 1'b0;
              r_err      <= 1'b1;
              r_err_code <= r_valid ? c_CODE_ORDER : c_CODE_ILLEGAL;
            end
          end
          default: begin
            r_state <= ST_HUNT;
          end
        endcase
      end
    end
  end

  assign Phase_Index = r_index;
  assign Valid       = r_valid;
  assign Locked      = r_locked;
  assign Rev_Count   = r_rev_count;
  assign Rev_Tick    = r_rev_tick;
  assign Err         = r_err;
  assign Err_Code    = r_err_code;

endmodule
`default_nettype wire
